// File: rtl/prog_fifo.sv
// Synchronous FIFO with programmable almost-empty/almost-full thresholds.
// Define FIFO_ERR_STICKY_EN to hold error until reset or init; otherwise error pulses.
module prog_fifo #(
  parameter int DATA_W = 6,
  parameter int DEPTH  = 8,
  parameter int CNT_W  = 5
) (
  input  logic              clk,
  input  logic              RESET_L,
  input  logic              init,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] data_in,
  input  logic [CNT_W-1:0]  thr_low,
  input  logic [CNT_W-1:0]  thr_high,
  output logic [DATA_W-1:0] data_out,
  output logic              valid,
  output logic [CNT_W-1:0]  count,
  output logic              empty,
  output logic              full,
  output logic              almost_empty,
  output logic              almost_full,
  output logic              error
);

  // state     | meaning
  // ST_INIT   | waiting for init; push/pop ignored
  // ST_ACTIVE | normal FIFO operation
  typedef enum logic {ST_INIT, ST_ACTIVE} state_t;

  localparam int PTR_W = $clog2(DEPTH);

  state_t              state_q;
  logic [PTR_W-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]    count_q, count_d;
  logic [CNT_W-1:0]    thr_low_q, thr_high_q;
  logic [DATA_W-1:0]   data_q;
  logic                valid_q, error_q, error_d;
  logic [DATA_W-1:0]   mem_q [DEPTH];

  logic active, is_empty, is_full, do_push, do_pop, overflow, underflow;

  assign active    = RESET_L && (state_q == ST_ACTIVE);
  assign is_empty  = (count_q == '0);
  assign is_full   = (count_q == CNT_W'(DEPTH));
  // A pop frees a slot in the same cycle, so push on full is legal alongside it.
  assign do_pop    = active && pop && !is_empty;
  assign do_push   = active && push && (!is_full || pop);
  assign overflow  = active && push && is_full && !pop;
  assign underflow = active && pop && is_empty;

  always_comb begin
    count_d = count_q;
    if (do_push && !do_pop)      count_d = count_q + CNT_W'(1);
    else if (do_pop && !do_push) count_d = count_q - CNT_W'(1);
  end

  always_comb begin
`ifdef FIFO_ERR_STICKY_EN
    error_d = overflow || underflow || (error_q && !init);
`else
    error_d = overflow || underflow;
`endif
  end

  always_ff @(posedge clk) begin
    if (!RESET_L) begin
      state_q    <= ST_INIT;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      data_q     <= '0;
      valid_q    <= 1'b0;
      error_q    <= 1'b0;
      thr_low_q  <= CNT_W'(1);
      thr_high_q <= CNT_W'(DEPTH - 1);
    end else begin
      count_q <= count_d;
      error_q <= error_d;
      valid_q <= do_pop;
      if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (do_pop) begin
        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
        data_q   <= mem_q[rd_ptr_q];
      end
      if (init) begin
        thr_low_q  <= thr_low;
        thr_high_q <= thr_high;
      end
      if (state_q == ST_INIT && init) state_q <= ST_ACTIVE;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= data_in;
  end

  assign data_out     = data_q;
  assign valid        = valid_q;
  assign count        = count_q;
  assign empty        = is_empty;
  assign full         = is_full;
  assign almost_empty = (count_q <= thr_low_q);
  assign almost_full  = (count_q >= thr_high_q);
  assign error        = error_q;

endmodule

// File: tb/tb_prog_fifo.sv
// Self-checking bench for prog_fifo: queue-based reference model compared every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_prog_fifo;
  localparam int DATA_W = 6;
  localparam int DEPTH  = 8;
  localparam int CNT_W  = 5;
`ifdef FIFO_ERR_STICKY_EN
  localparam bit STICKY = 1'b1;
`else
  localparam bit STICKY = 1'b0;
`endif

  logic clk = 1'b0;
  logic RESET_L, init, push, pop;
  logic [DATA_W-1:0] data_in, data_out;
  logic [CNT_W-1:0]  thr_low, thr_high, count;
  logic valid, empty, full, almost_empty, almost_full, error;

  prog_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .RESET_L(RESET_L), .init(init), .push(push), .pop(pop),
    .data_in(data_in), .thr_low(thr_low), .thr_high(thr_high),
    .data_out(data_out), .valid(valid), .count(count), .empty(empty),
    .full(full), .almost_empty(almost_empty), .almost_full(almost_full),
    .error(error)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  // reference model
  bit              m_active;
  logic [DATA_W-1:0] m_q[$];
  int              m_thr_lo, m_thr_hi;
  logic [DATA_W-1:0] m_dout;
  bit              m_valid, m_err;

  function automatic void check(string nm, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", nm, act, exp, $time);
    end
  endfunction

  function automatic void model_step(bit rst, bit in, bit pu, bit po,
                                     logic [DATA_W-1:0] d, int tl, int th);
    bit ov, un;
    if (!rst) begin
      m_active = 0; m_q.delete(); m_thr_lo = 1; m_thr_hi = DEPTH - 1;
      m_dout = '0; m_valid = 0; m_err = 0;
      return;
    end
    m_valid = 0;
    if (!m_active) begin
      m_err = STICKY && m_err && !in;
      if (in) begin m_thr_lo = tl; m_thr_hi = th; m_active = 1; end
      return;
    end
    ov = pu && m_q.size() == DEPTH && !po;
    un = po && m_q.size() == 0;
    if (po && m_q.size() > 0) begin m_dout = m_q.pop_front(); m_valid = 1; end
    if (pu && !ov) m_q.push_back(d);
    m_err = ov || un || (STICKY && m_err && !in);
    if (in) begin m_thr_lo = tl; m_thr_hi = th; end
  endfunction

  always @(negedge clk) begin
    if (chk_en) begin
      check("count", int'(count), m_q.size());
      check("empty", int'(empty), int'(m_q.size() == 0));
      check("full", int'(full), int'(m_q.size() == DEPTH));
      check("almost_empty", int'(almost_empty), int'(m_q.size() <= m_thr_lo));
      check("almost_full", int'(almost_full), int'(m_q.size() >= m_thr_hi));
      check("valid", int'(valid), int'(m_valid));
      check("data_out", int'(data_out), int'(m_dout));
      check("error", int'(error), int'(m_err));
    end
  end

  task automatic step(bit rst, bit in, bit pu, bit po,
                      logic [DATA_W-1:0] d, int tl, int th);
    RESET_L = rst; init = in; push = pu; pop = po; data_in = d;
    thr_low = CNT_W'(tl); thr_high = CNT_W'(th);
    @(posedge clk);
    model_step(rst, in, pu, po, d, tl, th);
    @(negedge clk);
  endtask

  task automatic idle();
    step(1, 0, 0, 0, '0, 0, 0);
  endtask

  logic [DATA_W-1:0] w [DEPTH];

  initial begin
    RESET_L = 0; init = 0; push = 0; pop = 0; data_in = '0; thr_low = '0; thr_high = '0;
    @(negedge clk);
    step(0, 0, 0, 0, '0, 0, 0);
    chk_en = 1'b1;
    step(0, 1, 1, 1, 6'h15, 7, 7);
    check("rst_count", int'(count), 0);
    check("rst_empty", int'(empty), 1);
    check("rst_full", int'(full), 0);
    check("rst_ae", int'(almost_empty), 1);
    check("rst_af", int'(almost_full), 0);
    check("rst_dout", int'(data_out), 0);

    step(1, 0, 1, 0, 6'h2A, 0, 0);
    check("init_push_ignored", int'(count), 0);
    check("init_no_error", int'(error), 0);
    step(1, 1, 0, 0, '0, 1, 3);
    check("act_empty", int'(empty), 1);
    check("act_ae", int'(almost_empty), 1);

    step(1, 0, 1, 0, 6'b001010, 0, 0);
    step(1, 0, 1, 0, 6'b110101, 0, 0);
    check("two_count", int'(count), 2);
    step(1, 0, 0, 1, '0, 0, 0);
    check("pop1_data", int'(data_out), 6'b001010);
    check("pop1_valid", int'(valid), 1);
    step(1, 0, 0, 1, '0, 0, 0);
    check("pop2_data", int'(data_out), 6'b110101);
    check("pop2_valid", int'(valid), 1);
    check("pop2_count", int'(count), 0);
    idle();
    check("idle_valid", int'(valid), 0);
    check("idle_hold", int'(data_out), 6'b110101);

    for (int i = 0; i < DEPTH; i++) begin
      w[i] = DATA_W'(i * 7 + 3);
      step(1, 0, 1, 0, w[i], 0, 0);
      if (i == 1) check("af_at2", int'(almost_full), 0);
      if (i == 2) check("af_at3", int'(almost_full), 1);
    end
    check("full_flag", int'(full), 1);
    check("full_count", int'(count), 8);
    step(1, 0, 1, 0, 6'h3E, 0, 0);
    check("ovf_error", int'(error), 1);
    check("ovf_count", int'(count), 8);
    idle();
    check("ovf_after", int'(error), int'(STICKY));
    step(1, 1, 0, 0, '0, 1, 3);
    check("reinit_count", int'(count), 8);
    check("reinit_err_clr", int'(error), 0);

    step(1, 0, 1, 1, 6'h3F, 0, 0);
    check("fullpp_count", int'(count), 8);
    check("fullpp_data", int'(data_out), int'(w[0]));
    check("fullpp_error", int'(error), 0);
    for (int i = 0; i < DEPTH; i++) step(1, 0, 0, 1, '0, 0, 0);
    check("drain_last", int'(data_out), 6'h3F);
    check("drain_empty", int'(empty), 1);

    step(1, 0, 1, 1, 6'h11, 0, 0);
    check("emptypp_count", int'(count), 1);
    check("emptypp_valid", int'(valid), 0);
    check("emptypp_error", int'(error), 1);
    idle();
    check("emptypp_after", int'(error), int'(STICKY));
    step(1, 1, 0, 0, '0, 1, 3);
    check("emptypp_init", int'(error), 0);

    for (int i = 0; i < 4; i++) step(1, 0, 1, 0, DATA_W'(i), 0, 0);
    check("five_count", int'(count), 5);
    step(0, 0, 0, 0, '0, 0, 0);
    check("rst5_count", int'(count), 0);
    check("rst5_empty", int'(empty), 1);
    step(1, 0, 1, 0, 6'h01, 0, 0);
    check("rst5_push_ign", int'(count), 0);

    for (int c = 0; c < 3000; c++) begin
      bit r, in, pu, po;
      int bias;
      bias = (c / 300) % 3;
      r  = ($urandom_range(0, 299) != 0);
      in = ($urandom_range(0, 39) == 0) || (!m_active && $urandom_range(0, 3) == 0);
      pu = $urandom_range(0, 9) < (bias == 0 ? 7 : (bias == 1 ? 3 : 5));
      po = $urandom_range(0, 9) < (bias == 0 ? 3 : (bias == 1 ? 7 : 5));
      step(r, in, pu, po, DATA_W'($urandom),
           $urandom_range(0, DEPTH), $urandom_range(0, DEPTH));
    end

    chk_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/prog_fifo.md
PROG_FIFO -- requirements
Module: prog_fifo

Interface
REQ-001 Parameter DATA_W, default 6, data word width.
REQ-002 Parameter DEPTH, default 8, number of entries; power of two, 4 to 64.
REQ-003 Parameter CNT_W, default 5, width of the threshold and count buses; must satisfy 2^CNT_W > DEPTH.
REQ-004 clk  in  1  single clock; all logic on rising edge.
REQ-005 RESET_L  in  1  synchronous, active-low reset.
REQ-006 init  in  1  threshold load strobe.
REQ-007 push  in  1  write request.
REQ-008 pop  in  1  read request.
REQ-009 data_in  in  DATA_W  write data.
REQ-010 thr_low  in  CNT_W  almost-empty threshold.
REQ-011 thr_high  in  CNT_W  almost-full threshold.
REQ-012 data_out  out  DATA_W  registered read data.
REQ-013 valid  out  1  data_out holds a popped word this cycle.
REQ-014 count  out  CNT_W  current occupancy, 0..DEPTH.
REQ-015 empty, full  out  1 each  count==0, count==DEPTH.
REQ-016 almost_empty, almost_full  out  1 each  programmable threshold flags.
REQ-017 error  out  1  overflow/underflow indication.

Function
REQ-018 FSM states: INIT and ACTIVE; reset enters INIT.
- INIT: push and pop are ignored, with no error; init=1 latches thr_low/thr_high; the FSM moves to ACTIVE on the next edge.
- ACTIVE: init=1 re-latches the thresholds; FIFO contents and count are preserved.
REQ-019 Accepted push writes data_in at the write pointer; pointers wrap modulo DEPTH.
REQ-020 Accepted pop: data_out is updated and valid=1 on the edge after pop; read latency is 1 cycle; otherwise valid=0 and data_out holds its last value.
REQ-021 push with full and no pop: push is dropped, contents are unchanged, and error is raised.
REQ-022 pop with empty: pop is dropped, valid stays 0, and error is raised; a simultaneous push is still accepted.
REQ-023 push and pop together, neither of REQ-021/REQ-022 applying: both are accepted and count is unchanged; this includes the full case.
REQ-024 count is registered: +1 on push-only, -1 on pop-only, unchanged otherwise.
REQ-025 Flags are combinational from registered count and latched thresholds:
- almost_empty = count <= thr_low_q
- almost_full = count >= thr_high_q
- the comparison is unsigned, at CNT_W bits
REQ-026 thr_low_q >= thr_high_q is legal; both flags follow their formulas independently.

Reset
REQ-027 RESET_L=0 at an edge forces:
- state=INIT, pointers=0, count=0, data_out=0, valid=0, error=0
- thr_low_q=1, thr_high_q=DEPTH-1
REQ-028 Reset during ACTIVE discards all stored data.
REQ-029 While reset is held: empty=1, full=0, almost_empty=1, almost_full=0; push, pop and init are ignored.

Configuration
REQ-030 Macro FIFO_ERR_STICKY_EN:
- defined: error stays 1 after any overflow or underflow until reset or an init pulse.
- undefined: error is a one-cycle pulse on the edge following each offending request.

Verification
REQ-031 Reset, then init with thr_low=1, thr_high=3 -> ACTIVE; empty=1, almost_empty=1, count=0, error=0.
REQ-032 Push 'b001010, then 'b110101; pop twice -> data_out 'b001010 then 'b110101 on successive cycles, valid=1 each, count back to 0.
REQ-033 With DEPTH=8, push 8 words -> almost_full=1 at count=3, full=1 at count=8; 9th push -> error=1, contents unchanged.
REQ-034 Full FIFO, push+pop in the same cycle -> count stays 8, oldest word is output, new word is stored, error=0.
REQ-035 Empty FIFO, push+pop in the same cycle -> count=1, valid=0, error=1; with FIFO_ERR_STICKY_EN, error holds until init; without it, error is a 1-cycle pulse.
REQ-036 RESET_L=0 with count=5 -> next edge count=0, empty=1, state=INIT; push before init is ignored.
